fpu_dispatch: RTL and testbench
===============================

// Module: fpu_dispatch
// PURPOSE
// Parametrised issue/response controller between the core and N_UNITS floating-point units
// (fadd, fsub, fmul, fdiv, fsqrt, ftoi, itof, fabs, ...). Takes one request per ready/valid
// handshake, starts the unit selected by a one-hot opcode, and waits for that unit's
// out_valid. It then returns the result, tag and ovf/unf flags through a response handshake
// with backpressure. Adds illegal-opcode rejection and a per-operation timeout.
// PARAMETERS
// N_UNITS  8   number of attached units; bit i of req_op selects unit i
// DATA_W   32  operand/result width
// TAG_W    4   request tag width, echoed on the response
// TIMEOUT  64  max cycles in BUSY before error response (>=2)
// PORTS
// sys_clk     in   1               clock, rising edge
// rstn        in   1               asynchronous active-low reset
// req_valid   in   1               request present
// req_ready   out  1               controller can accept a request
// req_op      in   N_UNITS         one-hot unit select
// req_tag     in   TAG_W           request tag
// req_x1      in   DATA_W          operand 1
// req_x2      in   DATA_W          operand 2
// unit_start  out  N_UNITS         one-cycle start pulse to the selected unit (its stage1_valid)
// unit_x1     out  DATA_W          registered operand 1, broadcast to all units
// unit_x2     out  DATA_W          registered operand 2, broadcast to all units
// unit_y      in   N_UNITS*DATA_W  unit results; unit i occupies [i*DATA_W +: DATA_W]
// unit_valid  in   N_UNITS         unit out_valid pulses
// unit_ovf    in   N_UNITS         unit overflow flags (tie 0 if unused)
// unit_unf    in   N_UNITS         unit underflow flags (tie 0 if unused)
// rsp_valid   out  1               response present
// rsp_ready   in   1               consumer accepts response
// rsp_y       out  DATA_W          result (0 on error)
// rsp_tag     out  TAG_W           tag of the completed request
// rsp_ovf     out  1               overflow flag
// rsp_unf     out  1               underflow flag
// rsp_err     out  1               1 = illegal opcode or timeout
// BEHAVIOUR
// - Reset (async, rstn=0): state IDLE. All outputs 0 except req_ready=1. Internal counter,
//   tag and unit select cleared. Reset mid-operation abandons it; any later unit_valid is ignored.
// - FSM IDLE -> BUSY -> RESP -> IDLE. req_ready=1 only in IDLE. Accept when req_valid&&req_ready.
// - IDLE accept, legal op (exactly one bit of req_op set):
//   - latch op, tag and operands into unit_x1/x2;
//   - unit_start = op for exactly the next cycle;
//   - enter BUSY with the counter at 0.
// - IDLE accept, illegal op (zero or more than one bit set): no unit_start; go directly to RESP
//   with rsp_err=1, rsp_y=0, ovf=unf=0.
// - BUSY: counter increments each cycle. unit_valid is checked only for the latched unit, and
//   only from the cycle after unit_start; pulses from other units are ignored. On the selected
//   unit's valid, capture its y/ovf/unf into the response registers and enter RESP; rsp_valid
//   rises the next cycle (1 cycle registered latency). Total latency:
//   accept@T, start@T+1, unit valid@T+1+L -> rsp_valid@T+2+L.
// - Timeout: if counter reaches TIMEOUT-1 without valid, enter RESP with rsp_err=1, rsp_y=0.
//   If valid and timeout coincide in the same cycle, valid wins (err=0).
// - RESP: rsp_* held stable while rsp_valid && !rsp_ready. On the handshake: rsp_valid=0 and
//   IDLE on the next cycle, so req_ready=1 one cycle after the handshake. No overlap of requests.
// - Late unit_valid arriving in RESP/IDLE after a timeout is discarded; it never produces a
//   second response.
// - unit_x1/x2 hold their value until the next accepted legal request.
// TESTING
// - Legal op: op=8'h04, x1=3F800000, x2=40000000, tag=5, unit 2 valid 3 cycles after start with
//   y=40000000 -> one response y=40000000, tag=5, err=0, rsp_valid 1 cycle after unit valid.
// - Backpressure: rsp_ready=0 for 10 cycles -> rsp_* constant, req_ready=0; then rsp_ready=1
//   -> single handshake, req_ready=1 next cycle.
// - Illegal ops: op=8'h00 and op=8'h03 -> no unit_start bit ever set; rsp_err=1, y=0, tag echoed.
// - Timeout: TIMEOUT=8, unit never valid -> err response after 8 BUSY cycles; late unit_valid
//   afterwards -> no extra response.
// - Foreign valid: unit 5 selected, unit 1 pulses valid -> ignored; unit 5 valid -> its y returned.
// - Reset mid-op: rstn low while BUSY -> all outputs 0, req_ready=1; stale unit valid after
//   release -> no response.

Source files
------------

// File: rtl/fpu_dispatch.sv
// Issue/response controller between the core and a bank of floating-point units.
// One operation in flight at a time; illegal opcodes and stuck units produce an error response.
module fpu_dispatch #(
  parameter int N_UNITS = 8,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                        sys_clk,
  input  logic                        rstn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [N_UNITS-1:0]          req_op,
  input  logic [TAG_W-1:0]            req_tag,
  input  logic [DATA_W-1:0]           req_x1,
  input  logic [DATA_W-1:0]           req_x2,
  output logic [N_UNITS-1:0]          unit_start,
  output logic [DATA_W-1:0]           unit_x1,
  output logic [DATA_W-1:0]           unit_x2,
  input  logic [N_UNITS*DATA_W-1:0]   unit_y,
  input  logic [N_UNITS-1:0]          unit_valid,
  input  logic [N_UNITS-1:0]          unit_ovf,
  input  logic [N_UNITS-1:0]          unit_unf,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_y,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic                        rsp_ovf,
  output logic                        rsp_unf,
  output logic                        rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_UNITS-1:0]  op_q, op_d;
  logic [N_UNITS-1:0]  unit_start_q, unit_start_d;
  logic [DATA_W-1:0]   x1_q, x1_d, x2_q, x2_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_y_q, rsp_y_d;
  logic                rsp_ovf_q, rsp_ovf_d;
  logic                rsp_unf_q, rsp_unf_d;
  logic                rsp_err_q, rsp_err_d;

  logic                op_legal;
  logic                sel_valid, sel_ovf, sel_unf;
  logic [DATA_W-1:0]   sel_y;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign op_legal  = (req_op != '0) && ((req_op & (req_op - N_UNITS'(1))) == '0);
  assign sel_valid = |(unit_valid & op_q);
  assign sel_ovf   = |(unit_ovf & op_q);
  assign sel_unf   = |(unit_unf & op_q);

  always_comb begin
    sel_y = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (op_q[i]) sel_y = sel_y | unit_y[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    unit_start_d = '0;
    x1_d         = x1_q;
    x2_d         = x2_q;
    tag_d        = tag_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_y_d      = rsp_y_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_unf_d    = rsp_unf_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tag_d       = req_tag;
          req_ready_d = 1'b0;
          if (op_legal) begin
            op_d         = req_op;
            unit_start_d = req_op;
            x1_d         = req_x1;
            x2_d         = req_x2;
            cnt_d        = '0;
            state_d      = BUSY;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_y_d     = '0;
            rsp_ovf_d   = 1'b0;
            rsp_unf_d   = 1'b0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The start cycle itself is excluded so a stale pulse cannot complete the new op.
        if (unit_start_q == '0 && sel_valid) begin
          rsp_valid_d = 1'b1;
          rsp_y_d     = sel_y;
          rsp_ovf_d   = sel_ovf;
          rsp_unf_d   = sel_unf;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_y_d     = '0;
          rsp_ovf_d   = 1'b0;
          rsp_unf_d   = 1'b0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      unit_start_q <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      tag_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_y_q      <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_unf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      unit_start_q <= unit_start_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      tag_q        <= tag_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_y_q      <= rsp_y_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_unf_q    <= rsp_unf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign unit_start = unit_start_q;
  assign unit_x1    = x1_q;
  assign unit_x2    = x2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_tag    = tag_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_unf    = rsp_unf_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch: directed scenarios then random transactions, each cycle
// compared against a latency/result model derived from the request and unit behaviour.
module tb_fpu_dispatch;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int TO = 8;

  logic              sys_clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [N-1:0]      req_op = '0;
  logic [TW-1:0]     req_tag = '0;
  logic [DW-1:0]     req_x1 = '0, req_x2 = '0;
  logic [N-1:0]      unit_start;
  logic [DW-1:0]     unit_x1, unit_x2;
  logic [N*DW-1:0]   unit_y = '0;
  logic [N-1:0]      unit_valid = '0, unit_ovf = '0, unit_unf = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DW-1:0]     rsp_y;
  logic [TW-1:0]     rsp_tag;
  logic              rsp_ovf, rsp_unf, rsp_err;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] last_x1 = '0, last_x2 = '0;

  fpu_dispatch #(.N_UNITS(N), .DATA_W(DW), .TAG_W(TW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .req_x1(req_x1), .req_x2(req_x2),
    .unit_start(unit_start), .unit_x1(unit_x1), .unit_x2(unit_x2),
    .unit_y(unit_y), .unit_valid(unit_valid), .unit_ovf(unit_ovf), .unit_unf(unit_unf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_tag(rsp_tag),
    .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .rsp_err(rsp_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_onehot(input logic [N-1:0] v);
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(v[i]);
    return n == 1;
  endfunction

  // Cycle c=0 is the accept cycle. The selected unit pulses valid in cycle 1+lat (lat<0: never);
  // unit fu (if >=0) pulses valid in cycle 1+flat. The consumer stalls bp cycles on the response.
  task automatic run_txn(input logic [N-1:0] op, input logic [TW-1:0] tag,
                         input logic [DW-1:0] x1, input logic [DW-1:0] x2, input logic [DW-1:0] y_sel,
                         input bit ovf, input bit unf, input int lat, input int bp,
                         input int fu, input int flat);
    logic [DW-1:0] ys [N];
    logic [DW-1:0] ey;
    bit legal, eerr, eovf, eunf;
    int sel, c_exp, h, last;
    legal = is_onehot(op);
    sel = 0;
    for (int i = 0; i < N; i++) if (op[i]) sel = i;
    for (int i = 0; i < N; i++) ys[i] = $urandom;
    if (legal) ys[sel] = y_sel;
    for (int i = 0; i < N; i++) unit_y[i*DW +: DW] = ys[i];
    unit_ovf = (N'($urandom) & ~op) | (ovf ? op : '0);
    unit_unf = (N'($urandom) & ~op) | (unf ? op : '0);

    if (!legal) begin
      c_exp = 1; eerr = 1; ey = '0; eovf = 0; eunf = 0;
    end else if (lat >= 1 && lat <= TO - 1) begin
      c_exp = 2 + lat; eerr = 0; ey = y_sel; eovf = ovf; eunf = unf;
    end else begin
      c_exp = 1 + TO; eerr = 1; ey = '0; eovf = 0; eunf = 0;
    end
    h = c_exp + bp;
    last = h + 3;
    if (legal && lat >= 0 && lat + 3 > last) last = lat + 3;
    if (fu >= 0 && flat + 3 > last) last = flat + 3;
    if (legal) begin
      last_x1 = x1;
      last_x2 = x2;
    end

    for (int c = 0; c <= last; c++) begin
      @(negedge sys_clk);
      check("req_ready", req_ready, (c == 0 || c > h));
      check("unit_start", unit_start, (legal && c == 1) ? op : '0);
      check("rsp_valid", rsp_valid, (c >= c_exp && c <= h));
      if (c >= 1) begin
        check("unit_x1", unit_x1, last_x1);
        check("unit_x2", unit_x2, last_x2);
      end
      if (c >= c_exp && c <= h) begin
        check("rsp_y", rsp_y, ey);
        check("rsp_tag", rsp_tag, tag);
        check("rsp_err", rsp_err, eerr);
        check("rsp_ovf", rsp_ovf, eovf);
        check("rsp_unf", rsp_unf, eunf);
      end
      req_valid = (c == 0);
      req_op = op; req_tag = tag; req_x1 = x1; req_x2 = x2;
      unit_valid = '0;
      if (legal && lat >= 0 && c == 1 + lat) unit_valid = unit_valid | op;
      if (fu >= 0 && c == 1 + flat) unit_valid[fu] = 1'b1;
      rsp_ready = (c >= h) || (c < c_exp && ($urandom % 2 == 1));
    end
    req_valid = 1'b0;
    unit_valid = '0;
    $display("[TB] txn op=%02h tag=%0h lat=%0d bp=%0d fu=%0d err=%0b y=%08h", op, tag, lat, bp, fu, eerr, ey);
  endtask

  initial begin
    logic [N-1:0] rop;
    int fu;
    // Reset state
    repeat (2) @(negedge sys_clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_unit_start", unit_start, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    rstn = 1'b1;
    @(negedge sys_clk);

    // Legal op on unit 2, valid 3 cycles after start
    run_txn(8'h04, 4'd5, 32'h3F800000, 32'h40000000, 32'h40000000, 0, 0, 3, 0, -1, 0);
    // Backpressure for 10 cycles
    run_txn(8'h08, 4'd9, 32'h11111111, 32'h22222222, 32'hC0490FDB, 1, 0, 2, 10, -1, 0);
    // Illegal opcodes
    run_txn(8'h00, 4'd3, 32'hDEADBEEF, 32'h0BADF00D, 32'h0, 0, 0, 2, 1, -1, 0);
    run_txn(8'h03, 4'd7, 32'hCAFEF00D, 32'h12345678, 32'h0, 0, 0, 2, 0, 0, 1);
    // Timeout with late valid in IDLE, then late valid in RESP
    run_txn(8'h40, 4'd2, 32'h1, 32'h2, 32'h7F800000, 1, 1, 10, 0, -1, 0);
    run_txn(8'h01, 4'd4, 32'h3, 32'h4, 32'h00000001, 0, 1, 8, 3, -1, 0);
    // Valid coinciding with the last count wins
    run_txn(8'h80, 4'd6, 32'h5, 32'h6, 32'h00ABCDEF, 0, 1, TO - 1, 0, -1, 0);
    // Foreign valid ignored, then unit 5 returns its result
    run_txn(8'h20, 4'd1, 32'h7, 32'h8, 32'h41200000, 0, 0, 4, 0, 1, 2);

    // Reset mid-operation
    @(negedge sys_clk);
    req_valid = 1'b1; req_op = 8'h10; req_tag = 4'hA; req_x1 = 32'hAAAA5555; req_x2 = 32'h5555AAAA;
    @(negedge sys_clk);
    req_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_unit_start", unit_start, '0);
    check("mid_rst_unit_x1", unit_x1, '0);
    check("mid_rst_unit_x2", unit_x2, '0);
    check("mid_rst_rsp_y", rsp_y, '0);
    check("mid_rst_rsp_tag", rsp_tag, '0);
    check("mid_rst_flags", {rsp_err, rsp_ovf, rsp_unf}, 3'b000);
    @(negedge sys_clk);
    rstn = 1'b1;
    last_x1 = '0;
    last_x2 = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      check("stale_rsp_valid", rsp_valid, 1'b0);
      check("stale_req_ready", req_ready, 1'b1);
      unit_valid = (c == 1) ? 8'h10 : 8'h00;
    end
    unit_valid = '0;
    $display("[TB] txn reset mid-op, stale valid discarded");

    // Random transactions
    for (int t = 0; t < 25; t++) begin
      if ($urandom % 4 == 0) rop = N'($urandom);
      else rop = N'(1) << ($urandom % N);
      fu = -1;
      if ($urandom % 2 == 1) begin
        fu = int'($urandom % N);
        if (rop[fu]) fu = -1;
      end
      run_txn(rop, TW'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
              int'($urandom_range(1, 11)), int'($urandom_range(0, 3)), fu, int'($urandom_range(1, 8)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
